// File: rtl/conv_window_scheduler.sv
// Buffers one IMG_H x IMG_W feature map plus a 3x3 weight set, then streams every valid
// 3x3 window (stride 1) to the MAC engine and counts results. `TAP_GATE_EN adds tap_en.
module conv_window_scheduler #(
    parameter int IMG_W = 7,
    parameter int IMG_H = 7,
    parameter int DW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            pix_valid,
    input  logic [DW-1:0]   pix_data,
    output logic            pix_ready,
    input  logic            wgt_load,
    input  logic [9*DW-1:0] wgt_data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [9*DW-1:0] win_data,
    output logic            w_valid,
    output logic [9*DW-1:0] w_data,
    input  logic            res_valid,
    output logic            busy,
    output logic            done,
    output logic            err
`ifdef TAP_GATE_EN
    ,
    output logic [8:0]      tap_en
`endif
);

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);
    localparam int PCW   = $clog2(N_PIX + 1);
    localparam int OCW   = $clog2(N_OUT + 1);
    localparam int AW    = $clog2(N_PIX);
    localparam int CW    = $clog2(IMG_W);

    localparam logic [PCW-1:0] N_PIX_C    = PCW'(N_PIX);
    localparam logic [OCW-1:0] N_OUT_C    = OCW'(N_OUT);
    localparam logic [OCW-1:0] LAST_WIN_C = OCW'(N_OUT - 1);
    localparam logic [CW-1:0]  LAST_COL_C = CW'(IMG_W - 3);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
    logic [OCW-1:0]    win_cnt_q, win_cnt_d;
    logic [OCW-1:0]    res_cnt_q, res_cnt_d;
    logic [AW-1:0]     base_q, base_d;
    logic [CW-1:0]     col_q, col_d;
    logic              wgt_ok_q, wgt_ok_d;
    logic              err_q, err_d;
    logic              w_valid_q, w_valid_d;
    logic [9*DW-1:0]   w_data_q, w_data_d;
    logic              win_valid_q, win_valid_d;
    logic [9*DW-1:0]   win_data_q, win_data_d;

    logic [DW-1:0]     pix_mem [N_PIX];
    logic [AW-1:0]     nxt_base, rd_base;
    logic [CW-1:0]     nxt_col;
    logic [9*DW-1:0]   win_taps;
    logic [9*DW-1:0]   wgt_next;

    always_ff @(posedge clk) begin
        if (pix_valid && pix_ready) begin
            pix_mem[pix_cnt_q[AW-1:0]] <= pix_data;
        end
    end

    // base_q is the raster address of the window's top-left tap; wrapping a row skips the
    // two columns that cannot start a window.
    always_comb begin
        if (col_q == LAST_COL_C) begin
            nxt_col  = '0;
            nxt_base = base_q + AW'(3);
        end else begin
            nxt_col  = col_q + CW'(1);
            nxt_base = base_q + AW'(1);
        end
        rd_base = win_valid_q ? nxt_base : base_q;
    end

    for (genvar gi = 0; gi < 9; gi++) begin : g_tap
        localparam int OFF = (gi / 3) * IMG_W + (gi % 3);
        assign win_taps[DW*gi +: DW] = pix_mem[rd_base + AW'(OFF)];
    end

    assign wgt_next = (state_q == S_LOAD && wgt_load) ? wgt_data : w_data_q;

`ifdef TAP_GATE_EN
    logic [8:0] tap_en_q, tap_en_d;
    logic [8:0] w_nz;
    for (genvar gi = 0; gi < 9; gi++) begin : g_nz
        assign w_nz[gi] = |wgt_next[DW*gi +: DW];
    end
    assign tap_en = tap_en_q;
`endif

    always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        win_cnt_d   = win_cnt_q;
        res_cnt_d   = res_cnt_q;
        base_d      = base_q;
        col_d       = col_q;
        wgt_ok_d    = wgt_ok_q;
        err_d       = err_q;
        w_valid_d   = 1'b0;
        w_data_d    = w_data_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
`ifdef TAP_GATE_EN
        tap_en_d    = tap_en_q;
`endif
        if ((state_q == S_ISSUE || state_q == S_DRAIN) && res_valid) begin
            if (res_cnt_q == N_OUT_C) err_d = 1'b1;
            else                      res_cnt_d = res_cnt_q + OCW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pix_cnt_d = '0;
                    win_cnt_d = '0;
                    res_cnt_d = '0;
                    base_d    = '0;
                    col_d     = '0;
                    wgt_ok_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (pix_valid && pix_ready) pix_cnt_d = pix_cnt_q + PCW'(1);
                if (wgt_load) wgt_ok_d = 1'b1;
                w_data_d = wgt_next;
                if (pix_cnt_q == N_PIX_C && wgt_ok_q) begin
                    state_d   = S_ISSUE;
                    w_valid_d = 1'b1;
`ifdef TAP_GATE_EN
                    tap_en_d  = w_nz;
`endif
                end
            end
            S_ISSUE: begin
`ifdef TAP_GATE_EN
                // All-zero weights: the engine output is known, so skip the whole pass.
                if (!win_valid_q && wgt_ok_q && tap_en_q == 9'd0) begin
                    res_cnt_d = N_OUT_C;
                    state_d   = S_DONE;
                end else
`endif
                if (!win_valid_q) begin
                    win_valid_d = 1'b1;
                    win_data_d  = win_taps;
                end else if (win_ready) begin
                    win_cnt_d = win_cnt_q + OCW'(1);
                    if (win_cnt_q == LAST_WIN_C) begin
                        win_valid_d = 1'b0;
                        state_d     = S_DRAIN;
                    end else begin
                        base_d     = nxt_base;
                        col_d      = nxt_col;
                        win_data_d = win_taps;
                    end
                end
            end
            S_DRAIN: begin
                if (res_cnt_q == N_OUT_C) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pix_cnt_q   <= '0;
            win_cnt_q   <= '0;
            res_cnt_q   <= '0;
            base_q      <= '0;
            col_q       <= '0;
            wgt_ok_q    <= 1'b0;
            err_q       <= 1'b0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
`ifdef TAP_GATE_EN
            tap_en_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            win_cnt_q   <= win_cnt_d;
            res_cnt_q   <= res_cnt_d;
            base_q      <= base_d;
            col_q       <= col_d;
            wgt_ok_q    <= wgt_ok_d;
            err_q       <= err_d;
            w_valid_q   <= w_valid_d;
            w_data_q    <= w_data_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
`ifdef TAP_GATE_EN
            tap_en_q    <= tap_en_d;
`endif
        end
    end

    assign pix_ready = (state_q == S_LOAD) && (pix_cnt_q < N_PIX_C);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign w_valid   = w_valid_q;
    assign w_data    = w_data_q;
    assign win_valid = win_valid_q;
    assign win_data  = win_data_q;

endmodule
